// File: rtl/connect4_pkg.sv
// Shared constants for the connect4 turn controller: board geometry, key codes,
// FSM state encodings and winner encodings.
package connect4_pkg;

  localparam int unsigned COLS  = 7;
  localparam int unsigned ROWS  = 6;
  localparam int unsigned COL_W = 3;
  localparam int unsigned HGT_W = 3;
  localparam int unsigned KEY_W = 4;
  localparam int unsigned ST_W  = 3;

  localparam logic [KEY_W-1:0] KEY_COL_LO = 4'h1;
  localparam logic [KEY_W-1:0] KEY_COL_HI = 4'h7;
  localparam logic [KEY_W-1:0] KEY_DROP   = 4'hA;
  localparam logic [KEY_W-1:0] KEY_POP    = 4'hB;
  localparam logic [KEY_W-1:0] KEY_CLR    = 4'hC;
  localparam logic [KEY_W-1:0] KEY_NEW    = 4'hE;

  localparam logic [COL_W-1:0] COL_NONE = 3'd7;

  localparam logic [ST_W-1:0] S_SELECT    = 3'd0;
  localparam logic [ST_W-1:0] S_ISSUE     = 3'd1;
  localparam logic [ST_W-1:0] S_WAIT_ACK  = 3'd2;
  localparam logic [ST_W-1:0] S_CHECK     = 3'd3;
  localparam logic [ST_W-1:0] S_REJECT    = 3'd4;
  localparam logic [ST_W-1:0] S_GAME_OVER = 3'd5;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/connect4_move_check.sv
// Combinational move legality: drop needs headroom, pop needs a piece owned by
// the side to move. Also reports a completely full board.
module connect4_move_check
  import connect4_pkg::*;
(
  input  logic [COL_W-1:0]      col,
  input  logic                  pop,
  input  logic                  player,
  input  logic [HGT_W*COLS-1:0] col_height,
  input  logic [COLS-1:0]       bottom_owner,
  output logic                  legal,
  output logic                  board_full
);

  logic [COLS-1:0] col_hit;
  logic [COLS-1:0] col_full;
  logic [COLS-1:0] col_empty;
  logic            sel_room;
  logic            sel_piece;
  logic            sel_mine;

  // One-hot column select; index 7 (no column) selects nothing and is never legal
  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign col_hit[c]   = (col == COL_W'(c));
    assign col_full[c]  = (col_height[HGT_W*c +: HGT_W] == HGT_W'(ROWS));
    assign col_empty[c] = (col_height[HGT_W*c +: HGT_W] == '0);
  end

  assign sel_room   = |(col_hit & ~col_full);
  assign sel_piece  = |(col_hit & ~col_empty);
  assign sel_mine   = |(col_hit & ~(bottom_owner ^ {COLS{player}}));
  assign legal      = pop ? (sel_piece && sel_mine) : sel_room;
  assign board_full = &col_full;

endmodule

// File: rtl/connect4_turn_ctrl.sv
// Connect4 turn sequencer: turns keypad presses into validated drop/pop commands
// over a valid/ack handshake, with turn, ack and error-flash timers.
module connect4_turn_ctrl
  import connect4_pkg::*;
#(
  parameter int unsigned TURN_TIMEOUT = 50_000_000,
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter int unsigned ERR_HOLD     = 25_000_000
) (
  input  logic                  myClk,
  input  logic                  reset_n,
  input  logic [KEY_W-1:0]      keypadButton,
  input  logic                  key_valid,
  input  logic [HGT_W*COLS-1:0] col_height,
  input  logic [COLS-1:0]       bottom_owner,
  input  logic                  win_valid,
  input  logic                  win_player,
  output logic                  move_valid,
  output logic [COL_W-1:0]      col,
  output logic                  pop,
  input  logic                  move_ack,
  output logic                  player,
  output logic [COL_W-1:0]      currColumn,
  output logic                  err_flash,
  output logic                  game_over,
  output logic [1:0]            winner,
  output logic                  fault
);

  localparam int unsigned TURN_W = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam int unsigned ACK_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned ERR_W  = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;

  logic [ST_W-1:0]   state_q, state_d;
  logic              move_valid_q, move_valid_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              pop_q, pop_d;
  logic              player_q, player_d;
  logic [COL_W-1:0]  curr_col_q, curr_col_d;
  logic              err_flash_q, err_flash_d;
  logic              game_over_q, game_over_d;
  logic [1:0]        winner_q, winner_d;
  logic              fault_q, fault_d;
  logic              win_seen_q, win_seen_d;
  logic              win_plr_q, win_plr_d;
  logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
  logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic             key_col, key_drop, key_pop, key_clr, key_new;
  logic [COL_W-1:0] key_col_idx;
  logic             restart, legal, board_full;
  logic             turn_hit, ack_hit, err_hit, in_handshake;

  assign key_col     = key_valid && (keypadButton >= KEY_COL_LO) && (keypadButton <= KEY_COL_HI);
  assign key_drop    = key_valid && (keypadButton == KEY_DROP);
  assign key_pop     = key_valid && (keypadButton == KEY_POP);
  assign key_clr     = key_valid && (keypadButton == KEY_CLR);
  assign key_new     = key_valid && (keypadButton == KEY_NEW);
  assign key_col_idx = COL_W'(keypadButton - KEY_COL_LO);

  // A new game never abandons a command that is still waiting for its ack
  assign in_handshake = (state_q == S_ISSUE) || (state_q == S_WAIT_ACK);
  assign restart      = key_new && !in_handshake;

  assign turn_hit = (turn_cnt_q == TURN_W'(TURN_TIMEOUT - 1));
  assign ack_hit  = (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1));
  assign err_hit  = (err_cnt_q == ERR_W'(ERR_HOLD - 1));

  connect4_move_check u_move_check (
    .col          (curr_col_q),
    .pop          (key_pop),
    .player       (player_q),
    .col_height   (col_height),
    .bottom_owner (bottom_owner),
    .legal        (legal),
    .board_full   (board_full)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    move_valid_d = move_valid_q;
    col_d        = col_q;
    pop_d        = pop_q;
    player_d     = player_q;
    curr_col_d   = curr_col_q;
    err_flash_d  = err_flash_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    fault_d      = fault_q;
    win_seen_d   = win_seen_q;
    win_plr_d    = win_plr_q;
    turn_cnt_d   = turn_cnt_q;
    ack_cnt_d    = ack_cnt_q;
    err_cnt_d    = err_cnt_q;

    if (restart) begin
      state_d     = S_SELECT;
      player_d    = 1'b1;
      curr_col_d  = COL_NONE;
      err_flash_d = 1'b0;
      game_over_d = 1'b0;
      winner_d    = WIN_NONE;
      fault_d     = 1'b0;
      turn_cnt_d  = '0;
    end else begin
      case (state_q)
        S_SELECT, S_REJECT: begin
          if (win_valid) begin
            state_d     = S_GAME_OVER;
            game_over_d = 1'b1;
            winner_d    = {win_player, ~win_player};
            err_flash_d = 1'b0;
          end else if (turn_hit) begin
            state_d     = S_SELECT;
            turn_cnt_d  = '0;
            player_d    = ~player_q;
            curr_col_d  = COL_NONE;
            err_flash_d = 1'b0;
          end else begin
            turn_cnt_d = turn_cnt_q + 1'b1;
            if (key_col) begin
              state_d     = S_SELECT;
              curr_col_d  = key_col_idx;
              err_flash_d = 1'b0;
            end else if (key_clr) begin
              state_d     = S_SELECT;
              curr_col_d  = COL_NONE;
              err_flash_d = 1'b0;
            end else if (state_q == S_REJECT) begin
              if (err_hit) begin
                state_d     = S_SELECT;
                err_flash_d = 1'b0;
              end else begin
                err_cnt_d = err_cnt_q + 1'b1;
              end
            end else if ((key_drop || key_pop) && (curr_col_q != COL_NONE)) begin
              if (legal) begin
                state_d      = S_ISSUE;
                move_valid_d = 1'b1;
                col_d        = curr_col_q;
                pop_d        = key_pop;
                ack_cnt_d    = '0;
                win_seen_d   = 1'b0;
              end else begin
                state_d     = S_REJECT;
                err_flash_d = 1'b1;
                err_cnt_d   = '0;
              end
            end
          end
        end
        S_ISSUE, S_WAIT_ACK: begin
          state_d = S_WAIT_ACK;
          if (win_valid) begin
            win_seen_d = 1'b1;
            win_plr_d  = win_player;
          end
          if (move_ack) begin
            state_d      = S_CHECK;
            move_valid_d = 1'b0;
            player_d     = ~player_q;
            curr_col_d   = COL_NONE;
            turn_cnt_d   = '0;
          end else if (ack_hit) begin
            state_d      = S_GAME_OVER;
            move_valid_d = 1'b0;
            fault_d      = 1'b1;
            game_over_d  = 1'b1;
            winner_d     = WIN_NONE;
          end else begin
            ack_cnt_d = ack_cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          // A win strobe arriving in this very cycle still counts and beats a draw
          if (win_seen_q || win_valid) begin
            state_d     = S_GAME_OVER;
            game_over_d = 1'b1;
            winner_d    = win_valid ? {win_player, ~win_player} : {win_plr_q, ~win_plr_q};
          end else if (board_full) begin
            state_d     = S_GAME_OVER;
            game_over_d = 1'b1;
            winner_d    = WIN_DRAW;
          end else begin
            state_d = S_SELECT;
          end
        end
        S_GAME_OVER: begin
          state_d = S_GAME_OVER;
        end
        default: begin
          state_d = S_SELECT;
        end
      endcase
    end
  end

  always_ff @(posedge myClk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_SELECT;
      move_valid_q <= 1'b0;
      col_q        <= '0;
      pop_q        <= 1'b0;
      player_q     <= 1'b1;
      curr_col_q   <= COL_NONE;
      err_flash_q  <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= WIN_NONE;
      fault_q      <= 1'b0;
      win_seen_q   <= 1'b0;
      win_plr_q    <= 1'b0;
      turn_cnt_q   <= '0;
      ack_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      move_valid_q <= move_valid_d;
      col_q        <= col_d;
      pop_q        <= pop_d;
      player_q     <= player_d;
      curr_col_q   <= curr_col_d;
      err_flash_q  <= err_flash_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      fault_q      <= fault_d;
      win_seen_q   <= win_seen_d;
      win_plr_q    <= win_plr_d;
      turn_cnt_q   <= turn_cnt_d;
      ack_cnt_q    <= ack_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign move_valid = move_valid_q;
  assign col        = col_q;
  assign pop        = pop_q;
  assign player     = player_q;
  assign currColumn = curr_col_q;
  assign err_flash  = err_flash_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// Bench for connect4_turn_ctrl: directed game scenarios plus randomized play,
// all outputs compared every cycle against a game-level reference model.
module tb_connect4_turn_ctrl;

  localparam int TT = 100;
  localparam int AT = 16;
  localparam int EH = 20;

  logic        myClk = 1'b0;
  logic        reset_n;
  logic [3:0]  key;
  logic        key_valid;
  logic [20:0] col_height;
  logic [6:0]  own;
  logic        win_valid;
  logic        win_player;
  logic        move_ack;
  logic        move_valid;
  logic [2:0]  col;
  logic        pop;
  logic        player;
  logic [2:0]  currColumn;
  logic        err_flash;
  logic        game_over;
  logic [1:0]  winner;
  logic        fault;

  int h[7];
  int checks   = 0;
  int failures = 0;
  int mv_hi    = 0;
  int ack_wait = -1;

  always #5 myClk = ~myClk;

  always_comb begin
    col_height = '0;
    for (int c = 0; c < 7; c++) col_height[3*c +: 3] = 3'(h[c]);
  end

  connect4_turn_ctrl #(.TURN_TIMEOUT(TT), .ACK_TIMEOUT(AT), .ERR_HOLD(EH)) dut (
    .myClk(myClk), .reset_n(reset_n), .keypadButton(key), .key_valid(key_valid),
    .col_height(col_height), .bottom_owner(own), .win_valid(win_valid),
    .win_player(win_player), .move_valid(move_valid), .col(col), .pop(pop),
    .move_ack(move_ack), .player(player), .currColumn(currColumn),
    .err_flash(err_flash), .game_over(game_over), .winner(winner), .fault(fault)
  );

  // Game-level reference: what the controller is doing, not how it encodes it
  typedef enum {M_IDLE, M_REJ, M_CMD, M_SETTLE, M_OVER} mode_e;
  mode_e      m_mode;
  bit         m_mv, m_pop, m_player, m_err, m_over, m_fault, m_wseen, m_wp;
  int         m_col, m_cur, m_turn, m_errc, m_ackc;
  logic [1:0] m_winner;

  task automatic model_reset();
    m_mode = M_IDLE; m_mv = 0; m_col = 0; m_pop = 0; m_player = 1; m_cur = 7;
    m_err = 0; m_over = 0; m_winner = 2'b00; m_fault = 0; m_wseen = 0; m_wp = 0;
    m_turn = 0; m_errc = 0; m_ackc = 0;
  endtask

  task automatic model_restart();
    m_mode = M_IDLE; m_player = 1; m_cur = 7; m_err = 0; m_over = 0;
    m_winner = 2'b00; m_fault = 0; m_turn = 0;
  endtask

  task automatic game_end(logic [1:0] w);
    m_over = 1; m_winner = w; m_err = 0; m_mode = M_OVER;
  endtask

  function automatic bit all_full();
    for (int c = 0; c < 7; c++) if (h[c] != 6) return 0;
    return 1;
  endfunction

  function automatic bit move_ok(int c, bit is_pop);
    if (is_pop) return (h[c] > 0) && (own[c] == m_player);
    return h[c] < 6;
  endfunction

  task automatic model_step();
    int k;
    bit kc, kd, kp, kclr, knew;
    k    = int'(key);
    kc   = key_valid && (k >= 1) && (k <= 7);
    kd   = key_valid && (k == 10);
    kp   = key_valid && (k == 11);
    kclr = key_valid && (k == 12);
    knew = key_valid && (k == 14);
    case (m_mode)
      M_IDLE, M_REJ: begin
        if (knew) model_restart();
        else if (win_valid) game_end({win_player, ~win_player});
        else if (m_turn == TT - 1) begin
          m_turn = 0; m_player = !m_player; m_cur = 7; m_err = 0; m_mode = M_IDLE;
        end else begin
          m_turn++;
          if (kc) begin m_cur = k - 1; m_err = 0; m_mode = M_IDLE; end
          else if (kclr) begin m_cur = 7; m_err = 0; m_mode = M_IDLE; end
          else if (m_mode == M_REJ) begin
            if (m_errc == EH - 1) begin m_err = 0; m_mode = M_IDLE; end
            else m_errc++;
          end else if ((kd || kp) && m_cur != 7) begin
            if (move_ok(m_cur, kp)) begin
              m_mv = 1; m_col = m_cur; m_pop = kp; m_mode = M_CMD; m_ackc = 0; m_wseen = 0;
            end else begin
              m_err = 1; m_errc = 0; m_mode = M_REJ;
            end
          end
        end
      end
      M_CMD: begin
        if (win_valid) begin m_wseen = 1; m_wp = win_player; end
        if (move_ack) begin
          m_mv = 0; m_player = !m_player; m_cur = 7; m_turn = 0; m_mode = M_SETTLE;
        end else if (m_ackc == AT - 1) begin
          m_mv = 0; m_fault = 1; game_end(2'b00);
        end else m_ackc++;
      end
      M_SETTLE: begin
        if (knew) model_restart();
        else if (win_valid) game_end({win_player, ~win_player});
        else if (m_wseen) game_end({m_wp, ~m_wp});
        else if (all_full()) game_end(2'b11);
        else m_mode = M_IDLE;
      end
      default: if (knew) model_restart();
    endcase
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("move_valid", move_valid, m_mv);
    chk("col", col, m_col);
    chk("pop", pop, m_pop);
    chk("player", player, m_player);
    chk("currColumn", currColumn, m_cur);
    chk("err_flash", err_flash, m_err);
    chk("game_over", game_over, m_over);
    chk("winner", winner, m_winner);
    chk("fault", fault, m_fault);
  endtask

  task automatic tick();
    if (move_valid) mv_hi++;
    @(posedge myClk);
    if (!reset_n) model_reset(); else model_step();
    #1;
    key_valid = 0; win_valid = 0; move_ack = 0;
    @(negedge myClk);
    compare();
  endtask

  task automatic press(logic [3:0] k);
    key = k; key_valid = 1;
    tick();
  endtask

  task automatic set_all(int v);
    for (int c = 0; c < 7; c++) h[c] = v;
  endtask

  function automatic logic [3:0] pick_key();
    int r;
    r = $urandom_range(0, 19);
    if (r < 10) return 4'(1 + r % 7);
    if (r < 13) return 4'hA;
    if (r < 15) return 4'hB;
    if (r == 15) return 4'hC;
    if (r == 16) return 4'hE;
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic random_board();
    int r;
    r = $urandom_range(0, 9);
    for (int c = 0; c < 7; c++) begin
      int q;
      q = $urandom_range(0, 9);
      h[c] = (r == 0 || q < 3) ? 6 : (q < 5) ? 0 : $urandom_range(0, 6);
    end
    own = 7'($urandom);
  endtask

  initial begin
    reset_n = 0; key = 0; key_valid = 0; win_valid = 0; win_player = 0; move_ack = 0;
    own = '0; set_all(0);
    model_reset();
    tick(); tick();
    chk("rst_move_valid", move_valid, 0);
    chk("rst_col", col, 0);
    chk("rst_pop", pop, 0);
    chk("rst_player", player, 1);
    chk("rst_currColumn", currColumn, 7);
    chk("rst_err_flash", err_flash, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_winner", winner, 0);
    chk("rst_fault", fault, 0);
    reset_n = 1;

    // Drop in column 2, ack on the third command cycle
    press(4'h3); press(4'hA);
    chk("dropA_col", col, 2);
    chk("dropA_pop", pop, 0);
    mv_hi = 0;
    tick(); tick();
    move_ack = 1; tick();
    chk("dropA_mv_cycles", mv_hi, 3);
    chk("dropA_mv_low", move_valid, 0);
    chk("dropA_player", player, 0);
    chk("dropA_cur", currColumn, 7);
    tick();

    // Drop into a full column is rejected for ERR_HOLD cycles
    press(4'hE);
    h[4] = 6;
    press(4'h5); press(4'hA);
    chk("full_reject_mv", move_valid, 0);
    begin
      int n;
      n = 0;
      for (int i = 0; i < 3 * EH && err_flash; i++) begin n++; tick(); end
      chk("err_hold_cycles", n, EH);
    end
    chk("reject_player", player, 1);
    chk("reject_cur_kept", currColumn, 4);

    // Pop ownership
    press(4'hE);
    set_all(0); h[1] = 3; own = 7'b0000000;
    press(4'h2); press(4'hB);
    chk("pop_foreign_err", err_flash, 1);
    chk("pop_foreign_mv", move_valid, 0);
    press(4'hC);
    chk("clr_ends_reject", err_flash, 0);
    own[1] = 1'b1;
    press(4'h2); press(4'hB);
    chk("pop_own_mv", move_valid, 1);
    chk("pop_own_col", col, 1);
    chk("pop_own_pop", pop, 1);
    move_ack = 1; tick(); tick();

    // Board never acks
    press(4'hE);
    set_all(0);
    press(4'h1); press(4'hA);
    mv_hi = 0;
    for (int i = 0; i < 3 * AT && !fault; i++) tick();
    chk("ack_to_mv_cycles", mv_hi, AT);
    chk("ack_to_fault", fault, 1);
    chk("ack_to_game_over", game_over, 1);
    chk("ack_to_winner", winner, 0);
    chk("ack_to_mv", move_valid, 0);
    press(4'hE);
    chk("newgame_fault", fault, 0);
    chk("newgame_over", game_over, 0);
    chk("newgame_winner", winner, 0);

    // Win reported while settling
    press(4'h1); press(4'hA);
    move_ack = 1; tick();
    win_valid = 1; win_player = 1; tick();
    chk("win_game_over", game_over, 1);
    chk("win_winner", winner, 2);
    press(4'h1); press(4'hA);
    chk("over_ignores_keys", move_valid, 0);
    chk("over_cur", currColumn, 7);

    // Turn timeout
    press(4'hE);
    press(4'h3);
    for (int i = 0; i < TT - 2; i++) tick();
    chk("pre_timeout_player", player, 1);
    chk("pre_timeout_cur", currColumn, 2);
    tick();
    chk("timeout_player", player, 0);
    chk("timeout_cur", currColumn, 7);

    // Final drop fills the board
    set_all(6); h[0] = 5;
    press(4'h1); press(4'hA);
    chk("last_drop_mv", move_valid, 1);
    set_all(6); move_ack = 1; tick(); tick();
    chk("draw_game_over", game_over, 1);
    chk("draw_winner", winner, 3);

    // Reset during a handshake drops move_valid without a clock edge
    press(4'hE);
    set_all(0);
    press(4'h4); press(4'hA);
    chk("pre_reset_mv", move_valid, 1);
    reset_n = 0;
    #1;
    chk("async_reset_mv", move_valid, 0);
    model_reset();
    tick();
    reset_n = 1;

    // Randomized play with a reactive board
    for (int i = 0; i < 4000; i++) begin
      key_valid = ($urandom_range(0, 3) == 0);
      key = pick_key();
      win_valid = ($urandom_range(0, 99) == 0);
      win_player = 1'($urandom);
      if ($urandom_range(0, 39) == 0) random_board();
      move_ack = 0;
      if (move_valid) begin
        if (ack_wait < 0) ack_wait = ($urandom_range(0, 19) == 0) ? 40 : $urandom_range(0, 3);
        if (ack_wait == 0) move_ack = 1;
        ack_wait--;
      end else begin
        ack_wait = -1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
